// File: rtl/clip_pkg.sv
// rtl/clip_pkg.sv - shared types, default constants and width helper for the clip sequencer
//
// Contents:
//   seq_state_t          sequencer state encoding (IDLE, RECORD, PLAY, FINISH)
//   DEF_*                default clock, slot and clip-count constants
//   clip_width()         bit width for a value range of n, never below 1
package clip_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2,
        S_FINISH = 2'd3
    } seq_state_t;

    localparam int DEF_CLKS_PER_SAMPLE  = 6250;  // 50 MHz / 8 kHz
    localparam int DEF_SAMPLES_PER_CLIP = 8000;  // one second per slot
    localparam int DEF_NUM_CLIPS        = 2;

    // Width needed to index n distinct values; a single value still gets one bit
    function automatic int clip_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sample_prescaler.sv
// rtl/sample_prescaler.sv - sample-period counter with clear, enable and registered wrap strobe
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clr            restart the period (count := 0)
//   i_en             advance the count by one, wrapping at PERIOD-1
//   o_strobe         registered: high in the cycle the count sits at PERIOD-1
//   o_strobe_next    look-ahead of o_strobe, lets the parent register companion outputs
module sample_prescaler
    import clip_pkg::*;
#(
    parameter int PERIOD = DEF_CLKS_PER_SAMPLE
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_strobe,
    output logic o_strobe_next
);

    localparam int PW = clip_width(PERIOD);
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_cnt_next;
    logic          r_strobe;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clr) begin
            w_cnt_next = '0;
        end else if (i_en) begin
            w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // The strobe is registered from the next count so it lines up with the
    // cycle in which the counter actually holds PERIOD-1.
    assign o_strobe_next = (i_clr || i_en) && (w_cnt_next == LAST);
    assign o_strobe      = r_strobe;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_strobe <= o_strobe_next;
        end
    end

endmodule

// File: rtl/clip_sequencer.sv
// rtl/clip_sequencer.sv - record/playback pass sequencer for the clip sample RAM
//
// Optional feature macro: CLIP_LEN_TRACK_EN (per-slot recorded-length registers;
// playback then stops at the stored length instead of the full slot).
//
// Ports:
//   clock, reset          clock, asynchronous active-low reset
//   start                 pass request, sampled in IDLE only
//   PlayOrRecord          1 = record, 0 = play (sampled with start)
//   clipNum               slot select (sampled with start, must be < NUM_CLIPS)
//   abort                 end the active pass early
//   busy                  high in RECORD, PLAY and FINISH
//   sample_strobe         one pulse per sample period while active
//   mem_addr              clipNum*SAMPLES_PER_CLIP + sample index
//   mem_we, mem_re        sample_strobe qualified by RECORD / PLAY
//   done                  one-cycle pulse in FINISH
module clip_sequencer
    import clip_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE  = DEF_CLKS_PER_SAMPLE,
    parameter int SAMPLES_PER_CLIP = DEF_SAMPLES_PER_CLIP,
    parameter int NUM_CLIPS        = DEF_NUM_CLIPS
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic                                            PlayOrRecord,
    input  logic [clip_width(NUM_CLIPS)-1:0]                clipNum,
    input  logic                                            abort,
    output logic                                            busy,
    output logic                                            sample_strobe,
    output logic [clip_width(NUM_CLIPS*SAMPLES_PER_CLIP)-1:0] mem_addr,
    output logic                                            mem_we,
    output logic                                            mem_re,
    output logic                                            done
);

    localparam int AW = clip_width(NUM_CLIPS * SAMPLES_PER_CLIP);
    localparam int IW = clip_width(SAMPLES_PER_CLIP);
    localparam int LW = clip_width(SAMPLES_PER_CLIP + 1);  // lengths reach SAMPLES_PER_CLIP

    seq_state_t    r_state, w_state_next;
    logic [AW-1:0] r_base, w_base_next, r_addr;
    logic [IW-1:0] r_idx, w_idx_next;
    logic [LW-1:0] r_limit, w_limit_next;
    logic [LW-1:0] w_play_limit;
    logic [LW-1:0] w_written;
    logic          r_busy, r_we, r_re, r_done;
    logic          w_clr, w_en, w_strobe, w_strobe_next, w_clip_ok;

    sample_prescaler #(
        .PERIOD(CLKS_PER_SAMPLE)
    ) u_prescaler (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .i_clr        (w_clr),
        .i_en         (w_en),
        .o_strobe     (w_strobe),
        .o_strobe_next(w_strobe_next)
    );

    assign w_clip_ok = (int'(clipNum) < NUM_CLIPS);
    // Samples committed so far, counting a strobe being issued this cycle
    assign w_written = LW'(r_idx) + LW'(w_strobe);

`ifdef CLIP_LEN_TRACK_EN
    logic [LW-1:0] r_len [NUM_CLIPS];
    logic [clip_width(NUM_CLIPS)-1:0] r_slot;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CLIPS; i++) r_len[i] <= '0;
            r_slot <= '0;
        end else begin
            if (r_state == S_IDLE && w_state_next != S_IDLE) r_slot <= clipNum;
            // Both natural completion and abort leave the written count behind
            if (r_state == S_RECORD && w_state_next == S_FINISH) r_len[r_slot] <= w_written;
        end
    end

    assign w_play_limit = w_clip_ok ? r_len[clipNum] : '0;
`else
    assign w_play_limit = LW'(SAMPLES_PER_CLIP);
`endif

    always_comb begin
        w_state_next = r_state;
        w_base_next  = r_base;
        w_idx_next   = r_idx;
        w_limit_next = r_limit;
        w_clr        = 1'b0;
        w_en         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_clip_ok) begin
                    w_state_next = PlayOrRecord ? S_RECORD : S_PLAY;
                    w_base_next  = AW'(clipNum) * AW'(SAMPLES_PER_CLIP);
                    w_idx_next   = '0;
                    w_limit_next = PlayOrRecord ? LW'(SAMPLES_PER_CLIP) : w_play_limit;
                    w_clr        = 1'b1;
                end
            end
            S_RECORD, S_PLAY: begin
                // The final strobe wins over abort only in the sense that it
                // was already issued this cycle; both lead to FINISH.
                if (r_limit == '0) begin
                    w_state_next = S_FINISH;
                end else if (w_strobe && (LW'(r_idx) == r_limit - 1'b1)) begin
                    w_state_next = S_FINISH;
                end else if (abort) begin
                    w_state_next = S_FINISH;
                end else begin
                    w_en = 1'b1;
                    if (w_strobe) w_idx_next = r_idx + 1'b1;
                end
            end
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_idx   <= '0;
            r_limit <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_base  <= w_base_next;
            r_idx   <= w_idx_next;
            r_limit <= w_limit_next;
            r_addr  <= w_base_next + AW'(w_idx_next);
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_FINISH);
            r_we    <= w_strobe_next && (w_state_next == S_RECORD);
            r_re    <= w_strobe_next && (w_state_next == S_PLAY);
        end
    end

    assign busy          = r_busy;
    assign sample_strobe = w_strobe;
    assign mem_addr      = r_addr;
    assign mem_we        = r_we;
    assign mem_re        = r_re;
    assign done          = r_done;

endmodule
